// File: rtl/sseg_frame_decoder.sv
// sseg_frame_decoder: receive-side decoder for the 3-digit multiplexed
// seven-segment bus. It synchronizes the enables and segments, waits for each
// digit slot to hold steady, inverts the segment table back to 5-bit symbol
// codes, and pulses frame_valid once all three slots have been captured.
module sseg_frame_decoder #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] an_in,
  input  logic [7:0] sseg_in,
  output logic [4:0] hex2,
  output logic [4:0] hex1,
  output logic [4:0] hex0,
  output logic [2:0] dp_out,
  output logic [2:0] en_out,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       an_err
);

  localparam int RW = $clog2(STABLE_CYCLES + 1);
  localparam logic [RW-1:0] R_MAX = RW'(STABLE_CYCLES);

  // two-flop synchronizers, then the previous synchronized value
  logic [2:0]         r_an_m, r_an_s, r_an_p;
  logic [7:0]         r_ss_m, r_ss_s, r_ss_p;
  logic [RW-1:0]      r_run;
  logic               r_first;
  logic [2:0][4:0]    r_hex;
  logic [2:0]         r_dp, r_en, r_mask;
  logic               r_fv, r_se, r_ae;

  logic               w_chg;
  logic [RW-1:0]      w_run_nxt;
  logic               w_slot_ok;
  logic [1:0]         w_slot;
  logic [4:0]         w_code;
  logic               w_known;
  logic               w_cap;
  logic [2:0]         w_mask_set;
  logic               w_an_ill;

  // Synchronize the raw bus; reset parks it at idle/blank.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an_m <= 3'b111;
      r_an_s <= 3'b111;
      r_ss_m <= 8'hFF;
      r_ss_s <= 8'hFF;
    end else begin
      r_an_m <= an_in;
      r_an_s <= r_an_m;
      r_ss_m <= sseg_in;
      r_ss_s <= r_ss_m;
    end
  end

  // Run-length of the current synchronized value, saturating at R_MAX.
  always_comb begin
    w_chg     = ({r_an_s, r_ss_s} != {r_an_p, r_ss_p});
    w_run_nxt = r_run;
    if (w_chg)               w_run_nxt = RW'(1);
    else if (r_run != R_MAX) w_run_nxt = r_run + RW'(1);
    w_an_ill  = !(r_an_s == 3'b110 || r_an_s == 3'b101 ||
                  r_an_s == 3'b011 || r_an_s == 3'b111);
  end

  // Track the dwell; r_first marks the single cycle the run first hits R_MAX,
  // while r_an_p/r_ss_p still hold the value that was stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an_p  <= 3'b111;
      r_ss_p  <= 8'hFF;
      r_run   <= '0;
      r_first <= 1'b0;
    end else begin
      r_an_p  <= r_an_s;
      r_ss_p  <= r_ss_s;
      r_run   <= w_run_nxt;
      r_first <= (w_run_nxt == R_MAX) && (r_run != R_MAX);
    end
  end

  // Slot select from the stable enable value (idle and illegal never capture).
  always_comb begin
    w_slot_ok = 1'b1;
    w_slot    = 2'd0;
    case (r_an_p)
      3'b110:  w_slot = 2'd0;
      3'b101:  w_slot = 2'd1;
      3'b011:  w_slot = 2'd2;
      default: w_slot_ok = 1'b0;
    endcase
    w_cap      = r_first && w_slot_ok;
    w_mask_set = r_mask | (3'b001 << w_slot);
  end

  // Inverse segment table; unknown patterns decode to 1F.
  always_comb begin
    w_known = 1'b1;
    w_code  = 5'h1F;
    case (r_ss_p[6:0])
      7'b0000001: w_code = 5'h00;
      7'b1001111: w_code = 5'h01;
      7'b0010010: w_code = 5'h02;
      7'b0000110: w_code = 5'h03;
      7'b1001100: w_code = 5'h04;
      7'b0100100: w_code = 5'h05;
      7'b0100000: w_code = 5'h06;
      7'b0001111: w_code = 5'h07;
      7'b0000000: w_code = 5'h08;
      7'b0000100: w_code = 5'h09;
      7'b0001000: w_code = 5'h0A;
      7'b1100000: w_code = 5'h0B;
      7'b0110001: w_code = 5'h0C;
      7'b1000010: w_code = 5'h0D;
      7'b0110000: w_code = 5'h0E;
      7'b0111000: w_code = 5'h0F;
      7'b1000001: w_code = 5'h10;
      7'b1111100: w_code = 5'h11;
      7'b1111111: w_code = 5'h12;
      7'b0001001: w_code = 5'h13;
      7'b1100010: w_code = 5'h14;
      7'b0011100: w_code = 5'h15;
      7'b1111001: w_code = 5'h16;
      7'b1001001: w_code = 5'h17;
      default:    w_known = 1'b0;
    endcase
  end

  // Capture into the slot registers, advance the seen mask, raise pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hex  <= {3{5'h12}};
      r_dp   <= '0;
      r_en   <= '0;
      r_mask <= '0;
      r_fv   <= 1'b0;
      r_se   <= 1'b0;
      r_ae   <= 1'b0;
    end else begin
      r_fv <= 1'b0;
      r_se <= 1'b0;
      r_ae <= w_an_ill && (r_an_s != r_an_p);
      if (w_cap) begin
        r_hex[w_slot] <= w_code;
        r_dp[w_slot]  <= ~r_ss_p[7];
        r_en[w_slot]  <= !(w_known && (r_ss_p[6:0] == 7'h7F));
        r_se          <= !w_known;
        if (w_mask_set == 3'b111) begin
          r_mask <= '0;
          r_fv   <= 1'b1;
        end else begin
          r_mask <= w_mask_set;
        end
      end
    end
  end

  assign hex0        = r_hex[0];
  assign hex1        = r_hex[1];
  assign hex2        = r_hex[2];
  assign dp_out      = r_dp;
  assign en_out      = r_en;
  assign frame_valid = r_fv;
  assign seg_err     = r_se;
  assign an_err      = r_ae;

endmodule
